fetch_sequencer: RTL and testbench

//  Controls the program counter for the fetch stage. Drives stall/change/npc to the PC register.

---
 rtl/fetch_sequencer.sv | 158 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: drives stall/change/npc to the PC register, arbitrates
// redirects (exception > jr > branch/jump), holds a redirect that arrives while the
// PC is stalled, runs the imem request/ready handshake and counts stall cycles.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int unsigned DELAY_SLOT = 1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hz_stall,
  input  logic        mdu_busy,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        jr_valid,
  input  logic [31:0] jr_target,
  input  logic        exc_valid,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        pc_stall,
  output logic        pc_change,
  output logic [31:0] pc_npc,
  output logic        flush_fd,
  output logic        fetch_err,
  output logic [31:0] stall_cnt
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [1:0]  pend_pri_q, pend_pri_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  wait_cnt_inc;
  logic        fetch_err_q, fetch_err_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        mem_stall;
  logic [1:0]  new_pri;
  logic [31:0] new_tgt;
  logic        take_new;
  logic        sel_v;
  logic [1:0]  sel_pri;
  logic [31:0] sel_tgt;

  // Encode this cycle's incoming redirect; priority 0 means none.
  always_comb begin
    new_pri = 2'd0;
    new_tgt = 32'd0;
    if (exc_valid) begin
      new_pri = 2'd3;
      new_tgt = EXC_VECTOR;
    end else if (jr_valid) begin
      new_pri = 2'd2;
      new_tgt = jr_target;
    end else if (br_valid) begin
      new_pri = 2'd1;
      new_tgt = br_target;
    end
  end

  // Pick between the new redirect and the held one; ties go to the newer request.
  always_comb begin
    take_new = (new_pri != 2'd0) && (new_pri >= pend_pri_q);
    sel_v    = take_new | pend_v_q;
    sel_pri  = take_new ? new_pri : pend_pri_q;
    sel_tgt  = take_new ? new_tgt : pend_tgt_q;
  end

  // Outputs to the PC register and imem; reset forces a quiet, stalled interface.
  always_comb begin
    imem_req  = ~reset & (state_q != ST_BOOT);
    imem_addr = pc_q;
    mem_stall = imem_req & ~imem_ready;
    pc_stall  = reset | hz_stall | mdu_busy | mem_stall | (state_q == ST_BOOT);
    pc_change = ~reset & sel_v;
    pc_npc    = pc_change ? sel_tgt : 32'd0;
    // Branch/jr leave the delay-slot instruction alive; exceptions always kill it.
    flush_fd  = pc_change & ~pc_stall & ((sel_pri == 2'd3) | (DELAY_SLOT == 0));
    fetch_err = fetch_err_q;
    stall_cnt = stall_cnt_q;
  end

  // Handshake FSM plus imem wait timeout.
  always_comb begin
    state_d      = state_q;
    wait_cnt_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
    wait_cnt_d   = 8'd0;
    fetch_err_d  = fetch_err_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  state_d = imem_ready ? ST_RUN : ST_WAIT;
      ST_WAIT: begin
        if (imem_ready) begin
          state_d = ST_RUN;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          if (wait_cnt_inc >= TIMEOUT_C) fetch_err_d = 1'b1;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // PC tracking, pending-redirect capture and the stall counter.
  always_comb begin
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_pri_d = pend_pri_q;
    pend_tgt_d = pend_tgt_q;
    if (pc_stall) begin
      if (take_new) begin
        pend_v_d   = 1'b1;
        pend_pri_d = new_pri;
        pend_tgt_d = new_tgt;
      end
    end else begin
      pc_d       = pc_change ? pc_npc : pc_q + 32'd4;
      pend_v_d   = 1'b0;
      pend_pri_d = 2'd0;
      pend_tgt_d = 32'd0;
    end
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      pend_v_q    <= 1'b0;
      pend_pri_q  <= 2'd0;
      pend_tgt_q  <= 32'd0;
      wait_cnt_q  <= 8'd0;
      fetch_err_q <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_v_q    <= pend_v_d;
      pend_pri_q  <= pend_pri_d;
      pend_tgt_q  <= pend_tgt_d;
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: the stimulus process predicts each cycle's
// outputs from a behavioural model and queues them; a monitor checks them on negedge.
// Two DUTs share inputs and differ only in DELAY_SLOT.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam int          TIMEOUT    = 16;

  typedef struct packed {
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic        change;
    logic [31:0] npc;
    logic        flush1;
    logic        flush0;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hz_stall = 1'b0, mdu_busy = 1'b0, br_valid = 1'b0, jr_valid = 1'b0;
  logic exc_valid = 1'b0, imem_ready = 1'b1;
  logic [31:0] br_target = 32'd0, jr_target = 32'd0;

  logic        req1, stall1, change1, flush1, err1;
  logic [31:0] addr1, npc1, cnt1;
  logic        req0, stall0, change0, flush0, err0;
  logic [31:0] addr0, npc0, cnt0;

  always #5 clk = ~clk;

  fetch_sequencer #(.DELAY_SLOT(1), .TIMEOUT(TIMEOUT)) dut1 (
    .clk(clk), .reset(reset), .hz_stall(hz_stall), .mdu_busy(mdu_busy),
    .br_valid(br_valid), .br_target(br_target), .jr_valid(jr_valid), .jr_target(jr_target),
    .exc_valid(exc_valid), .imem_ready(imem_ready), .imem_req(req1), .imem_addr(addr1),
    .pc_stall(stall1), .pc_change(change1), .pc_npc(npc1), .flush_fd(flush1),
    .fetch_err(err1), .stall_cnt(cnt1)
  );

  fetch_sequencer #(.DELAY_SLOT(0), .TIMEOUT(TIMEOUT)) dut0 (
    .clk(clk), .reset(reset), .hz_stall(hz_stall), .mdu_busy(mdu_busy),
    .br_valid(br_valid), .br_target(br_target), .jr_valid(jr_valid), .jr_target(jr_target),
    .exc_valid(exc_valid), .imem_ready(imem_ready), .imem_req(req0), .imem_addr(addr0),
    .pc_stall(stall0), .pc_change(change0), .pc_npc(npc0), .flush_fd(flush0),
    .fetch_err(err0), .stall_cnt(cnt0)
  );

  exp_t sb[$];
  int tests = 0;
  int failed = 0;

  // Reference model state: fetch address, boot/waiting phase, held redirect.
  logic [31:0] m_pc = RESET_PC;
  bit          m_boot = 1'b1;
  bit          m_waiting = 1'b0;
  int          m_wait = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_cnt = 32'd0;
  bit          m_pv = 1'b0;
  int          m_ppri = 0;
  logic [31:0] m_ptgt = 32'd0;

  task automatic drive(input logic rst, input logic hz, input logic mdu,
                       input logic br, input logic [31:0] bt,
                       input logic jr, input logic [31:0] jt,
                       input logic exc, input logic rdy);
    exp_t        e;
    int          np;
    logic [31:0] nt;
    bit          sv;
    int          sp;
    logic [31:0] st;
    bit          stl;
    @(posedge clk);
    #1;
    reset = rst; hz_stall = hz; mdu_busy = mdu; br_valid = br; br_target = bt;
    jr_valid = jr; jr_target = jt; exc_valid = exc; imem_ready = rdy;
    e = '0;
    e.rst = rst;
    e.addr = m_pc;
    e.err = m_err;
    e.cnt = m_cnt;
    if (rst) begin
      e.stall = 1'b1;
      m_pc = RESET_PC; m_boot = 1'b1; m_waiting = 1'b0; m_wait = 0; m_err = 1'b0;
      m_cnt = 32'd0; m_pv = 1'b0; m_ppri = 0; m_ptgt = 32'd0;
    end else begin
      np = exc ? 3 : jr ? 2 : br ? 1 : 0;
      nt = exc ? EXC_VECTOR : jr ? jt : br ? bt : 32'd0;
      e.req = !m_boot;
      stl = hz || mdu || m_boot || (!m_boot && !rdy);
      e.stall = stl;
      if (np != 0 && np >= m_ppri) begin
        sv = 1'b1; sp = np; st = nt;
      end else begin
        sv = m_pv; sp = m_ppri; st = m_ptgt;
      end
      e.change = sv;
      e.npc = sv ? st : 32'd0;
      e.flush1 = sv && !stl && sp == 3;
      e.flush0 = sv && !stl;
      if (stl) begin
        if (np != 0 && np >= m_ppri) begin
          m_pv = 1'b1; m_ppri = np; m_ptgt = nt;
        end
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end else begin
        m_pv = 1'b0; m_ppri = 0; m_ptgt = 32'd0;
        m_pc = sv ? st : m_pc + 32'd4;
      end
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (!m_waiting) begin
        m_waiting = !rdy;
      end else if (rdy) begin
        m_waiting = 1'b0; m_wait = 0;
      end else begin
        if (m_wait < 255) m_wait++;
        if (m_wait >= TIMEOUT) m_err = 1'b1;
      end
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: compare every queued expectation against both DUTs away from the edge.
  initial begin : monitor
    exp_t e;
    int   cyc;
    bit   ok;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cyc++;
        tests++;
        ok = (req1 === e.req) && (stall1 === e.stall) && (change1 === e.change) &&
             (npc1 === e.npc) && (flush1 === e.flush1) && (flush0 === e.flush0) &&
             (stall0 === e.stall) && (req0 === e.req);
        if (!e.rst)
          ok = ok && (addr1 === e.addr) && (addr0 === e.addr) && (err1 === e.err) &&
               (err0 === e.err) && (cnt1 === e.cnt);
        if (!ok) begin
          failed++;
          $display("FAIL cycle %0d (rst=%0b): got req=%0b addr=%h stall=%0b chg=%0b npc=%h fl1=%0b fl0=%0b err=%0b cnt=%0d addr0=%h, want req=%0b addr=%h stall=%0b chg=%0b npc=%h fl1=%0b fl0=%0b err=%0b cnt=%0d",
                   cyc, e.rst, req1, addr1, stall1, change1, npc1, flush1, flush0, err1,
                   cnt1, addr0, e.req, e.addr, e.stall, e.change, e.npc, e.flush1,
                   e.flush0, e.err, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    int          miss_left;
    logic        rdy;
    logic [31:0] t1, t2;
    // Reset, boot, sequential fetch.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(4);
    // Unstalled branch.
    drive(0, 0, 0, 1, 32'h3100, 0, 0, 0, 1);
    idle(3);
    // jr held across a hazard stall.
    drive(0, 1, 0, 0, 0, 1, 32'h3200, 0, 1);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // Pending branch overridden by exception, later branch dropped.
    drive(0, 0, 1, 1, 32'h5000, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 1, 1, 32'h6000, 0, 0, 0, 1);
    idle(2);
    // imem timeout with an exception latched during WAIT, then reset mid-wait.
    for (int i = 0; i < TIMEOUT + 4; i++) drive(0, 0, 0, 0, 0, 0, 0, (i == 3), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // Exception taken when imem_ready returns.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // All three at once, then PC wrap.
    drive(0, 0, 0, 1, 32'h7000, 1, 32'h8000, 1, 1);
    idle(1);
    drive(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 1);
    idle(3);
    // Randomized traffic.
    miss_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (miss_left == 0 && $urandom_range(0, 99) == 0) miss_left = $urandom_range(10, 24);
      if (miss_left > 0) begin
        rdy = 1'b0;
        miss_left--;
      end else begin
        rdy = ($urandom_range(0, 7) != 0);
      end
      t1 = $urandom;
      t2 = $urandom;
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), t1,
            ($urandom_range(0, 13) == 0), t2, ($urandom_range(0, 29) == 0), rdy);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
